ram_transpose_pingpong: RTL and testbench

//  Parametrised successor to the single-matrix column-read RAM. Rows of an N x N matrix of W-bit

---
 rtl/ram_transpose_pingpong_if.sv | 57 +++++
 rtl/ram_transpose_pingpong.sv | 145 ++++++++++++++
 tb/tb_ram_transpose_pingpong.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_transpose_pingpong_if.sv
// Bus bundle for ram_transpose_pingpong.
//
// Purpose: groups the row-write and column-read handshakes plus the
// bank-occupancy status into one interface.
//
// Signals:
//   wr_valid / wr_ready          row-write handshake
//   wr_be_n [N]                  active-low per-element write enable
//   wr_data [N*W]                row; element i = wr_data[(i+1)*W-1 : i*W]
//   rd_valid / rd_ready          column-read handshake
//   rd_data [N*W]                column; row 0's element in the MSBs
//   rd_last                      rd_data is the final column of its matrix
//   mat_count [2]                full banks awaiting or under readout
//   rd_transpose                 only with RAM_TRANSPOSE_ROWREAD_EN defined:
//                                1 = column read, 0 = plain row read
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and its
// payload stable until that transfer. rd_valid never depends on rd_ready
// in the same cycle.
//
// Modports: slave = the RAM, master = whoever writes rows and drains columns.
interface ram_transpose_pingpong_if #(
  parameter int W = 8,
  parameter int N = 8
);
  logic           wr_valid;
  logic           wr_ready;
  logic [N-1:0]   wr_be_n;
  logic [N*W-1:0] wr_data;
  logic           rd_valid;
  logic           rd_ready;
  logic [N*W-1:0] rd_data;
  logic           rd_last;
  logic [1:0]     mat_count;
`ifdef RAM_TRANSPOSE_ROWREAD_EN
  logic           rd_transpose;

  modport slave (
    input  wr_valid, wr_be_n, wr_data, rd_ready, rd_transpose,
    output wr_ready, rd_valid, rd_data, rd_last, mat_count
  );
  modport master (
    output wr_valid, wr_be_n, wr_data, rd_ready, rd_transpose,
    input  wr_ready, rd_valid, rd_data, rd_last, mat_count
  );
`else
  modport slave (
    input  wr_valid, wr_be_n, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last, mat_count
  );
  modport master (
    output wr_valid, wr_be_n, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last, mat_count
  );
`endif
endinterface

// File: rtl/ram_transpose_pingpong.sv
// ram_transpose_pingpong
//
// Purpose: ping-pong transpose RAM. Rows of an N x N matrix of W-bit
// elements are written into one bank while the other bank is read out
// column by column (column c = element N-1-c of every row, row 0 in the
// MSBs). A bank becomes full after its last row is written and is freed
// when its last column is loaded into the output register.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset
//   bus   ram_transpose_pingpong_if.slave (see interface file for signals)
//
// Option: RAM_TRANSPOSE_ROWREAD_EN adds bus.rd_transpose; when it is 0 at
// a column load, the output word is row rd_col of the read bank instead.
// Bank bookkeeping is the same in both modes.
module ram_transpose_pingpong #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  ram_transpose_pingpong_if.slave     bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  // Storage is deliberately not reset.
  logic [N*W-1:0] mem_q [2][N];

  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [RW-1:0]  wr_row_q, wr_row_d;
  logic [RW-1:0]  rd_col_q, rd_col_d;
  logic [1:0]     full_q, full_d;
  logic           wr_ready_q, wr_ready_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;
  logic [N*W-1:0] rd_data_q, rd_data_d;

  logic           wr_fire, wr_done, rd_load, rd_done;
  logic [RW-1:0]  rd_elem;
  logic [N*W-1:0] row_new, col_data, rd_word;

  // The registered status is masked while rst is high so no row is
  // accepted in a reset cycle.
  assign bus.wr_ready  = wr_ready_q & ~rst;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.mat_count = {full_q[0] & full_q[1], full_q[0] ^ full_q[1]};

  assign wr_fire = bus.wr_valid & bus.wr_ready;
  assign wr_done = wr_fire && (wr_row_q == RW'(N - 1));
  assign rd_load = (~rd_valid_q | bus.rd_ready) & full_q[rd_bank_q];
  assign rd_done = rd_load && (rd_col_q == RW'(N - 1));
  assign rd_elem = RW'(N - 1) - rd_col_q;

  // Merge new elements into the stored row according to the byte enables.
  always_comb begin
    row_new = mem_q[wr_bank_q][wr_row_q];
    for (int i = 0; i < N; i++) begin
      if (!bus.wr_be_n[i]) row_new[i*W +: W] = bus.wr_data[i*W +: W];
    end
  end

  // Gather element rd_elem of every row; row 0 lands in the MSBs.
  always_comb begin
    col_data = '0;
    for (int r = 0; r < N; r++) begin
      col_data[(N-1-r)*W +: W] = mem_q[rd_bank_q][r][rd_elem*W +: W];
    end
  end

`ifdef RAM_TRANSPOSE_ROWREAD_EN
  assign rd_word = bus.rd_transpose ? col_data : mem_q[rd_bank_q][rd_col_q];
`else
  assign rd_word = col_data;
`endif

  always_comb begin
    wr_row_d   = wr_row_q;
    wr_bank_d  = wr_bank_q;
    rd_col_d   = rd_col_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;

    if (wr_fire) begin
      wr_row_d = wr_done ? '0 : wr_row_q + 1'b1;
      if (wr_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (rd_load) begin
      rd_data_d  = rd_word;
      rd_valid_d = 1'b1;
      rd_last_d  = rd_done;
      rd_col_d   = rd_done ? '0 : rd_col_q + 1'b1;
      if (rd_done) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (bus.rd_ready) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    // Looks at the current full flags, so a bank freed this cycle becomes
    // writable one cycle after its freeing is visible. The bank being
    // filled now is never wr_bank_d once it completes, so no set is missed.
    wr_ready_d = ~full_q[wr_bank_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_col_q   <= '0;
      full_q     <= '0;
      wr_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_col_q   <= rd_col_d;
      full_q     <= full_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_row_q] <= row_new;
  end
endmodule

// File: tb/tb_ram_transpose_pingpong.sv
module tb_ram_transpose_pingpong;
  localparam int W  = 8;
  localparam int N  = 8;
  localparam int DW = N * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_transpose_pingpong_if #(.W(W), .N(N)) bus ();
  ram_transpose_pingpong #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  // Two banks of rows; each completed matrix pushes its N output words.
  logic [DW-1:0] mdl_mem [2][N];
  int            mdl_row  = 0;
  int            mdl_bank = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];

  initial begin
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < N; r++) mdl_mem[b][r] = '0;
  end

  task automatic push_matrix(input int bank);
    logic [DW-1:0] w;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) w[(N-1-r)*W +: W] = mdl_mem[bank][r][(N-1-c)*W +: W];
`ifdef RAM_TRANSPOSE_ROWREAD_EN
      if (!bus.rd_transpose) w = mdl_mem[bank][c];
`endif
      exp_q.push_back(w);
      exp_last_q.push_back(c == N - 1);
    end
  endtask

  // Inputs change just after posedge, so everything seen at negedge is
  // exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      mdl_row  = 0;
      mdl_bank = 0;
    end else begin
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_column: got %h expected none", bus.rd_data);
        end else begin
          check("rd_data", bus.rd_data, exp_q[0]);
          check("rd_last", DW'(bus.rd_last), DW'(exp_last_q[0]));
          if (bus.rd_ready) begin
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        for (int i = 0; i < N; i++)
          if (!bus.wr_be_n[i]) mdl_mem[mdl_bank][mdl_row][i*W +: W] = bus.wr_data[i*W +: W];
        if (mdl_row == N - 1) begin
          push_matrix(mdl_bank);
          mdl_row  = 0;
          mdl_bank = 1 - mdl_bank;
        end else begin
          mdl_row++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Callers are always just after a posedge.
  task automatic write_row(input logic [N-1:0] be_n, input logic [DW-1:0] data);
    bit acc = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_be_n  = be_n;
    bus.wr_data  = data;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = bus.wr_ready;
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL write_timeout: got no wr_ready expected wr_ready within 100 cycles");
    end
  endtask

  task automatic expect_col(input logic [DW-1:0] lit, input logic last, output int waited);
    bit hit = 1'b0;
    waited = 0;
    while (!hit && waited < 60) begin
      @(negedge clk);
      waited++;
      hit = bus.rd_valid && bus.rd_ready;
    end
    if (!hit) begin
      n_checks++;
      n_fails++;
      $display("FAIL col_timeout: got no column expected %h", lit);
    end else begin
      check("col_literal", bus.rd_data, lit);
      check("col_last_literal", DW'(bus.rd_last), DW'(last));
    end
  endtask

  task automatic drain();
    int k = 0;
    while (k < 200 && (exp_q.size() != 0 || bus.rd_valid)) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic write_random_matrix();
    for (int r = 0; r < N; r++) write_row('0, {$urandom, $urandom});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    int run, first_last, first_wr;
    bit in_run;
    logic [DW-1:0] d;

    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_be_n  = '1;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
`ifdef RAM_TRANSPOSE_ROWREAD_EN
    bus.rd_transpose = 1'b1;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wr_ready", DW'(bus.wr_ready), DW'(0));
    check("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
    check("rst_rd_data", bus.rd_data, '0);
    check("rst_mat_count", DW'(bus.mat_count), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wr_ready", DW'(bus.wr_ready), DW'(1));
    check("post_rst_rd_valid", DW'(bus.rd_valid), DW'(0));
    check("post_rst_mat_count", DW'(bus.mat_count), DW'(0));
    check("post_rst_rd_data", bus.rd_data, '0);
    @(posedge clk); #1;

    // Row r = {8{r}}: every column reads 00 01 .. 07.
    bus.rd_ready = 1'b1;
    for (int r = 0; r < N; r++) write_row('0, {N{8'(r)}});
    @(negedge clk);
    check("lat_mat_count", DW'(bus.mat_count), DW'(1));
    check("lat_rd_valid_low", DW'(bus.rd_valid), DW'(0));
    for (int c = 0; c < N; c++) begin
      expect_col(64'h0001020304050607, c == N - 1, w);
      if (c == 0) check("lat_first_col_wait", DW'(w), DW'(1));
    end
    check("mat_count_after_read", DW'(bus.mat_count), DW'(0));
    @(posedge clk); #1;

    // Same matrix into the second bank so both banks hold it.
    for (int r = 0; r < N; r++) write_row('0, {N{8'(r)}});
    drain();

    // Only element 0 of row 0 changes; column 7 carries it.
    write_row(8'hFE, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int r = 1; r < N; r++) write_row(8'hFF, {$urandom, $urandom});
    for (int c = 0; c < N; c++)
      expect_col((c == N - 1) ? 64'hFF01020304050607 : 64'h0001020304050607, c == N - 1, w);
    drain();

    // Two matrices with no reader: both banks full, writer blocked.
    bus.rd_ready = 1'b0;
    write_random_matrix();
    write_random_matrix();
    @(negedge clk);
    check("both_full_wr_ready", DW'(bus.wr_ready), DW'(0));
    check("both_full_mat_count", DW'(bus.mat_count), DW'(2));
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    run = 0; first_last = -1; first_wr = -1; in_run = 1'b1;
    fork
      write_random_matrix();
      begin
        for (int k = 1; k <= 40; k++) begin
          @(negedge clk);
          if (in_run && bus.rd_valid) run++;
          else in_run = 1'b0;
          if (first_last < 0 && bus.rd_valid && bus.rd_last) first_last = k;
          if (first_wr < 0 && bus.wr_ready) first_wr = k;
        end
      end
    join
    check("stall_run_len", DW'(run), DW'(16));
    check("wr_ready_after_last", DW'(first_wr - first_last), DW'(1));
    drain();

    // rd_ready toggles every cycle during readout.
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1;
          bus.rd_ready = k[0];
        end
      end
      write_random_matrix();
    join
    bus.rd_ready = 1'b1;
    drain();

    // Reset with one matrix mid-readout and a partial matrix in the other bank.
    bus.rd_ready = 1'b0;
    write_random_matrix();
    for (int r = 0; r < 5; r++) write_row('0, {$urandom, $urandom});
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_ready", DW'(bus.wr_ready), DW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_rd_valid", DW'(bus.rd_valid), DW'(0));
    check("midrst_rd_last", DW'(bus.rd_last), DW'(0));
    check("midrst_rd_data", bus.rd_data, '0);
    check("midrst_mat_count", DW'(bus.mat_count), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_wr_ready", DW'(bus.wr_ready), DW'(1));
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    for (int r = 0; r < N; r++) write_row('0, {N{8'(8'h10 + r)}});
    for (int c = 0; c < N; c++) expect_col(64'h1011121314151617, c == N - 1, w);
    drain();

`ifdef RAM_TRANSPOSE_ROWREAD_EN
    bus.rd_transpose = 1'b0;
    for (int r = 0; r < N; r++) write_row('0, {N{8'(8'h20 + r)}});
    for (int c = 0; c < N; c++) begin
      d = {N{8'(8'h20 + c)}};
      expect_col(d, c == N - 1, w);
    end
    drain();
    bus.rd_transpose = 1'b1;
`endif

    check("final_queue_empty", DW'(exp_q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #400000;
    n_fails++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "watchdog");
  end
endmodule
